// File: rtl/line_buffer_multi.sv
// Multi-row line buffer: emits one vertical column of ROWS taps per accepted pixel.
// Optional top-border replication of masked taps when LB_BORDER_REPLICATE_EN is defined.
module line_buffer_multi #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LINE_W = 320,
    parameter int unsigned ROWS   = 5,
    parameter int unsigned COL_W  = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     in_sof,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    output logic [ROWS*DATA_W-1:0]   out_taps,
    output logic [COL_W-1:0]         out_col,
    output logic [2:0]               out_row,
    output logic                     out_full
);

    localparam int unsigned DEPTH  = ROWS - 1;
    localparam int unsigned IDX_W  = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam int unsigned FILL_W = 3;

    logic [DATA_W-1:0]      line_mem [DEPTH][LINE_W];

    logic [COL_W-1:0]       col_q;
    logic [COL_W-1:0]       col_eff;
    logic [COL_W-1:0]       col_nxt;
    logic [FILL_W-1:0]      fill_q;
    logic [FILL_W-1:0]      fill_eff;
    logic [FILL_W-1:0]      fill_nxt;
    logic [IDX_W-1:0]       col_idx;
    logic [DATA_W-1:0]      tap_raw [ROWS];
    logic [DATA_W-1:0]      tap_deep;
    logic [ROWS*DATA_W-1:0] taps_c;

    // SOF resyncs the position before the current pixel is used
    always_comb begin
        col_eff  = in_sof ? '0 : col_q;
        fill_eff = in_sof ? '0 : fill_q;
        col_idx  = IDX_W'(col_eff);
        col_nxt  = col_eff + COL_W'(1);
        fill_nxt = fill_eff;
        if (col_eff == COL_W'(LINE_W - 1)) begin
            col_nxt = '0;
            if (fill_eff != FILL_W'(ROWS - 1)) begin
                fill_nxt = fill_eff + FILL_W'(1);
            end
        end
    end

    // Column taps: current pixel plus unmasked reads of the stored lines
    always_comb begin
        tap_raw[0] = in_data;
        for (int k = 1; k < ROWS; k++) begin
            tap_raw[k] = line_mem[k-1][col_idx];
        end
        tap_deep = in_data;
        for (int j = 0; j < ROWS; j++) begin
            if (FILL_W'(j) == fill_eff) begin
                tap_deep = tap_raw[j];
            end
        end
    end

    // Taps above the filled region come from a previous frame and are masked
    always_comb begin
        taps_c = '0;
        for (int k = 0; k < ROWS; k++) begin
            if (FILL_W'(k) > fill_eff) begin
`ifdef LB_BORDER_REPLICATE_EN
                taps_c[k*DATA_W +: DATA_W] = tap_deep;
`else
                taps_c[k*DATA_W +: DATA_W] = '0;
`endif
            end else begin
                taps_c[k*DATA_W +: DATA_W] = tap_raw[k];
            end
        end
    end

    // Position counters and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q     <= '0;
            fill_q    <= '0;
            out_valid <= 1'b0;
            out_taps  <= '0;
            out_col   <= '0;
            out_row   <= '0;
            out_full  <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                col_q    <= col_nxt;
                fill_q   <= fill_nxt;
                out_taps <= taps_c;
                out_col  <= col_eff;
                out_row  <= fill_eff;
                out_full <= (fill_eff == FILL_W'(ROWS - 1));
            end
        end
    end

    // Vertical shift through the line memories at the current column only
    always_ff @(posedge clk) begin
        if (in_valid && rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                line_mem[k][col_idx] <= tap_raw[k];
            end
        end
    end

endmodule

// File: tb/tb_line_buffer_multi.sv
// Scoreboard bench for line_buffer_multi (LINE_W=4, ROWS=3).
module tb_line_buffer_multi;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned LINE_W = 4;
    localparam int unsigned ROWS   = 3;
    localparam int unsigned COL_W  = 2;

    typedef struct packed {
        logic [ROWS*DATA_W-1:0] taps;
        logic [COL_W-1:0]       col;
        logic [2:0]             row;
        logic                   full;
    } exp_t;

    logic                   clk;
    logic                   rst;
    logic                   in_valid;
    logic                   in_sof;
    logic [DATA_W-1:0]      in_data;
    logic                   out_valid;
    logic [ROWS*DATA_W-1:0] out_taps;
    logic [COL_W-1:0]       out_col;
    logic [2:0]             out_row;
    logic                   out_full;

    exp_t        sb_q[$];
    int          n_checks;
    int          n_pass;
    int          pos;
    logic [7:0]  hist [0:63];
    logic        gap_pending;
    logic [1:0]  last_col;

    line_buffer_multi #(
        .DATA_W(DATA_W), .LINE_W(LINE_W), .ROWS(ROWS), .COL_W(COL_W)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
        .out_valid(out_valid), .out_taps(out_taps), .out_col(out_col),
        .out_row(out_row), .out_full(out_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Model: expected column from frame-position history of pixel values
    task automatic send(input logic sof, input logic [7:0] d);
        exp_t e;
        int   row;
        @(negedge clk);
        if (gap_pending) begin
            chk("gap_valid", 32'(out_valid), 32'd0);
            chk("gap_col_hold", 32'(out_col), 32'(last_col));
            gap_pending = 1'b0;
        end
        in_valid = 1'b1;
        in_sof   = sof;
        in_data  = d;
        if (sof) pos = 0;
        hist[pos] = d;
        row = (pos / 4 > 2) ? 2 : pos / 4;
        e.col  = 2'(pos % 4);
        e.row  = 3'(row);
        e.full = (row == 2);
        e.taps = '0;
        for (int k = 0; k < ROWS; k++) begin
            if (k <= row) e.taps[k*8 +: 8] = hist[pos - 4*k];
`ifdef LB_BORDER_REPLICATE_EN
            else e.taps[k*8 +: 8] = hist[pos - 4*row];
`endif
        end
        sb_q.push_back(e);
        last_col = e.col;
        pos++;
    endtask

    task automatic gap();
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b1;
        in_data  = 8'($urandom);
        gap_pending = 1'b1;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    // Monitor: pop and compare on every presented output
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("taps", 32'(out_taps), 32'(e.taps));
                    chk("col", 32'(out_col), 32'(e.col));
                    chk("row", 32'(out_row), 32'(e.row));
                    chk("full", 32'(out_full), 32'(e.full));
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_pass = 0;
        pos = 0;
        gap_pending = 1'b0;
        last_col = '0;
        rst = 1'b0;
        in_valid = 1'b1;
        in_sof = 1'b0;
        in_data = 8'hAA;

        // Reset held with active input
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_valid", 32'(out_valid), 32'd0);
            chk("rst_taps", 32'(out_taps), 32'd0);
            chk("rst_col", 32'(out_col), 32'd0);
            chk("rst_row", 32'(out_row), 32'd0);
            chk("rst_full", 32'(out_full), 32'd0);
        end
        in_valid = 1'b0;
        rst = 1'b1;

        // Fill: pixels 1..12
        for (int i = 1; i <= 12; i++) send(i == 1, 8'(i));

        // Same pattern with gaps (SOF in gaps must be ignored)
        for (int i = 1; i <= 12; i++) begin
            send(i == 1, 8'(8'h20 + i));
            gap();
        end

        // Long frame: fill count saturates
        for (int i = 1; i <= 40; i++) send(i == 1, 8'(8'h40 + i));

        // Mid-frame SOF on pixel 7
        for (int i = 1; i <= 12; i++) send(i == 1 || i == 7, 8'(i));

        // Async reset between edges
        send(1'b0, 8'h91);
        idle();
        #1 rst = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_taps", 32'(out_taps), 32'd0);
        chk("arst_col", 32'(out_col), 32'd0);
        chk("arst_row", 32'(out_row), 32'd0);
        chk("arst_full", 32'(out_full), 32'd0);
        #1 rst = 1'b1;
        pos = 0;
        for (int i = 1; i <= 6; i++) send(1'b0, 8'(8'hB0 + i));

        idle();
        idle();
        idle();
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
